// File: rtl/md_counter_up_syn_mod.sv
// Purpose: modulo-MODULUS up counter with enable, synchronous parallel load and a carry chain for cascading digits.
// Latency: count/wrap/ovf/lderr are registered (1 cycle); tc and cout are combinational in the same cycle.
// Backpressure: none; en and cin stall counting, and cout gates the next stage on the same edge.
module md_counter_up_syn_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16   // legal range 2 .. 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cin,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             cout,
    output logic             wrap,
    output logic             ovf,
    output logic             lderr
);

    // Terminal value held one bit wider so MODULUS == 2**WIDTH still fits and
    // an out-of-range din can be detected without truncation.
    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             ovf_nxt;
    logic             lderr_nxt;
    logic             din_ok;
    logic             step;

    assign count_inc = count + WIDTH'(1);
    assign din_ok    = ({1'b0, din} <= LAST);
    assign step      = en & cin;
    assign tc        = ({1'b0, count} == LAST);
    // A stage being loaded or reset must never hand a carry to the next digit.
    assign cout      = tc & step & ~load & rst;

    // Next-state selection: load beats counting, counting beats hold; pulses default low.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        ovf_nxt   = ovf;
        lderr_nxt = 1'b0;
        if (load) begin
            ovf_nxt = 1'b0;
            if (din_ok) begin
                count_nxt = din;
            end else begin
                count_nxt = '0;
                lderr_nxt = 1'b1;
            end
        end else if (step) begin
            if (tc) begin
                count_nxt = '0;
                wrap_nxt  = 1'b1;
                ovf_nxt   = 1'b1;
            end else begin
                count_nxt = count_inc;
            end
        end
    end

    // State register with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
            lderr <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
            ovf   <= ovf_nxt;
            lderr <= lderr_nxt;
        end
    end

endmodule

// File: tb/tb_md_counter_up_syn_mod.sv
// Purpose: self-checking bench for md_counter_up_syn_mod (mod-10, mod-16 and a two-digit BCD cascade).
// Latency: inputs driven 1 time unit after a rising edge; registered outputs sampled 1 unit after the next edge.
// Backpressure: not applicable; all waits are bounded clock edges plus a global watchdog.
module tb_md_counter_up_syn_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       cin = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = 4'd0;

    // mod-10 instance
    logic [3:0] count;
    logic       tc, cout, wrap, ovf, lderr;
    // mod-16 instance sharing the same inputs
    logic [3:0] count16;
    logic       tc16, cout16, wrap16, ovf16, lderr16;

    // BCD cascade
    logic       c_rst = 1'b0;
    logic       c_en = 1'b0;
    logic [3:0] lo_count, hi_count;
    logic       lo_tc, lo_cout, lo_wrap, lo_ovf, lo_lderr;
    logic       hi_tc, hi_cout, hi_wrap, hi_ovf, hi_lderr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    md_counter_up_syn_mod #(.WIDTH(4), .MODULUS(10)) u_dut (
        .clk(clk), .rst(rst), .en(en), .cin(cin), .load(load), .din(din),
        .count(count), .tc(tc), .cout(cout), .wrap(wrap), .ovf(ovf), .lderr(lderr)
    );

    md_counter_up_syn_mod #(.WIDTH(4), .MODULUS(16)) u_dut16 (
        .clk(clk), .rst(rst), .en(en), .cin(cin), .load(load), .din(din),
        .count(count16), .tc(tc16), .cout(cout16), .wrap(wrap16), .ovf(ovf16), .lderr(lderr16)
    );

    md_counter_up_syn_mod #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .cin(1'b1), .load(1'b0), .din(4'd0),
        .count(lo_count), .tc(lo_tc), .cout(lo_cout), .wrap(lo_wrap), .ovf(lo_ovf), .lderr(lo_lderr)
    );

    md_counter_up_syn_mod #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .rst(c_rst), .en(c_en), .cin(lo_cout), .load(1'b0), .din(4'd0),
        .count(hi_count), .tc(hi_tc), .cout(hi_cout), .wrap(hi_wrap), .ovf(hi_ovf), .lderr(hi_lderr)
    );

    typedef struct {
        logic       rst, en, cin, load;
        logic [3:0] din;
        logic       tc, cout;          // expected before the edge
        logic [3:0] cnt;               // expected after the edge
        logic       wrap, ovf, lderr;  // expected after the edge
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, e, c, l, input logic [3:0] d,
                                input logic t, co, input logic [3:0] n,
                                input logic w, o, le);
        vec_t v;
        v.rst = r; v.en = e; v.cin = c; v.load = l; v.din = d;
        v.tc = t; v.cout = co; v.cnt = n; v.wrap = w; v.ovf = o; v.lderr = le;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: next state from the counter rules in plain arithmetic.
    task automatic model_step(input int modulus, inout int c, inout int w, inout int o, inout int le);
        if (!rst) begin
            c = 0; w = 0; o = 0; le = 0;
        end else if (load) begin
            w = 0; o = 0;
            if (int'(din) < modulus) begin
                c = int'(din); le = 0;
            end else begin
                c = 0; le = 1;
            end
        end else if (en && cin) begin
            le = 0;
            c  = (c + 1) % modulus;
            w  = (c == 0) ? 1 : 0;
            if (w == 1) o = 1;
        end else begin
            w = 0; le = 0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_c, m_w, m_o, m_l;
        int s_c, s_w, s_o, s_l;
        int hi_wraps;
        int lo_wraps;
        logic exp_tc, exp_cout;

        // ---------------- reset ----------------
        rst = 1'b0; en = 1'b1; cin = 1'b1; load = 1'b1; din = 4'd5;
        edge_settle();
        edge_settle();
        chk("reset.count", count, 0);
        chk("reset.wrap", wrap, 0);
        chk("reset.ovf", ovf, 0);
        chk("reset.lderr", lderr, 0);
        chk("reset.tc", tc, 0);
        chk("reset.cout", cout, 0);

        // ---------------- directed table ----------------
        //            rst en cin ld din  tc co  cnt wr ov le
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  4, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  5, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  6, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  7, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  8, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  9, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   1, 1,  0, 1, 1, 0));  // 9 -> 0 wraps
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  2, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 7,   0, 0,  7, 0, 0, 0));  // load clears ovf
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  8, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 12,  0, 0,  0, 0, 0, 1));  // illegal load
        tbl.push_back(mk(1, 0, 1, 0, 0,   0, 0,  0, 0, 0, 0));  // lderr lasts one cycle
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  4, 0, 0, 0));  // en 1,0,0,1
        tbl.push_back(mk(1, 0, 1, 0, 0,   0, 0,  4, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0,   0, 0,  4, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  5, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  6, 0, 0, 0));  // cin 1,0,0,1
        tbl.push_back(mk(1, 1, 0, 0, 0,   0, 0,  6, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0,   0, 0,  6, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  7, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  8, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  9, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 2,   1, 0,  2, 0, 0, 0));  // load beats wrap at 9
        tbl.push_back(mk(1, 0, 1, 1, 10,  0, 0,  0, 0, 0, 1));  // din == MODULUS is illegal
        tbl.push_back(mk(1, 0, 1, 1, 9,   0, 0,  9, 0, 0, 0));  // din == MODULUS-1 is legal
        tbl.push_back(mk(1, 0, 1, 0, 0,   1, 0,  9, 0, 0, 0));  // tc without en: no carry
        tbl.push_back(mk(1, 1, 1, 0, 0,   1, 1,  0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0,   0, 0,  0, 0, 1, 0));  // hold keeps ovf
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  2, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  3, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  4, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  5, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0,   0, 0,  6, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 12,  0, 0,  0, 0, 0, 0));  // reset beats load/en
        tbl.push_back(mk(1, 0, 0, 0, 0,   0, 0,  0, 0, 0, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; en = tbl[i].en; cin = tbl[i].cin;
            load = tbl[i].load; din = tbl[i].din;
            #1;
            chk($sformatf("vec%0d.tc", i), tc, tbl[i].tc);
            chk($sformatf("vec%0d.cout", i), cout, tbl[i].cout);
            edge_settle();
            chk($sformatf("vec%0d.count", i), count, tbl[i].cnt);
            chk($sformatf("vec%0d.wrap", i), wrap, tbl[i].wrap);
            chk($sformatf("vec%0d.ovf", i), ovf, tbl[i].ovf);
            chk($sformatf("vec%0d.lderr", i), lderr, tbl[i].lderr);
        end

        // ---------------- reset is synchronous only ----------------
        rst = 1'b1; en = 1'b0; cin = 1'b1; load = 1'b1; din = 4'd5;
        edge_settle();
        chk("sync.loaded", count, 5);
        rst = 1'b0; load = 1'b0; en = 1'b1;
        #3;
        chk("sync.between_edges", count, 5);
        chk("sync.cout_in_reset", cout, 0);
        edge_settle();
        chk("sync.at_edge", count, 0);

        // ---------------- BCD cascade 00..99..00 ----------------
        c_rst = 1'b0; c_en = 1'b1;
        edge_settle();
        chk("bcd.reset_lo", lo_count, 0);
        chk("bcd.reset_hi", hi_count, 0);
        c_rst = 1'b1;
        hi_wraps = 0;
        lo_wraps = 0;
        for (int k = 1; k <= 100; k++) begin
            edge_settle();
            chk($sformatf("bcd%0d.lo", k), lo_count, k % 10);
            chk($sformatf("bcd%0d.hi", k), hi_count, (k / 10) % 10);
            chk($sformatf("bcd%0d.hi_wrap", k), hi_wrap, (k == 100) ? 1 : 0);
            if (hi_wrap) hi_wraps++;
            if (lo_wrap) lo_wraps++;
        end
        chk("bcd.hi_wrap_total", hi_wraps, 1);
        chk("bcd.lo_wrap_total", lo_wraps, 10);
        c_en = 1'b0;

        // ---------------- randomized vs reference model ----------------
        rst = 1'b0; load = 1'b0; en = 1'b0; cin = 1'b0;
        edge_settle();
        m_c = 0; m_w = 0; m_o = 0; m_l = 0;
        s_c = 0; s_w = 0; s_o = 0; s_l = 0;
        for (int n = 0; n < 1500; n++) begin
            rst  = ($urandom_range(0, 31) != 0);
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            cin  = ($urandom_range(0, 3) != 0);
            din  = 4'($urandom_range(0, 15));
            #1;
            exp_tc   = (m_c == 9);
            exp_cout = exp_tc & en & cin & ~load & rst;
            chk($sformatf("rnd%0d.tc", n), tc, exp_tc);
            chk($sformatf("rnd%0d.cout", n), cout, exp_cout);
            exp_tc   = (s_c == 15);
            exp_cout = exp_tc & en & cin & ~load & rst;
            chk($sformatf("rnd%0d.tc16", n), tc16, exp_tc);
            chk($sformatf("rnd%0d.cout16", n), cout16, exp_cout);
            model_step(10, m_c, m_w, m_o, m_l);
            model_step(16, s_c, s_w, s_o, s_l);
            edge_settle();
            chk($sformatf("rnd%0d.count", n), count, m_c);
            chk($sformatf("rnd%0d.wrap", n), wrap, m_w);
            chk($sformatf("rnd%0d.ovf", n), ovf, m_o);
            chk($sformatf("rnd%0d.lderr", n), lderr, m_l);
            chk($sformatf("rnd%0d.count16", n), count16, s_c);
            chk($sformatf("rnd%0d.wrap16", n), wrap16, s_w);
            chk($sformatf("rnd%0d.ovf16", n), ovf16, s_o);
            chk($sformatf("rnd%0d.lderr16", n), lderr16, s_l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
